// File: rtl/bs_input_pkg.sv
// Shared types and default timing constants for the board input front end.
package bs_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DEB_CYCLES  = 16;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing asynchronous board signals into the clock domain.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces the start button and slide switches feeding the
// bit-serial core, producing a single start pulse per press and a held switch word.
module input_conditioner
  import bs_input_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEFAULT_DEB_CYCLES
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_btn_start,
  input  logic [W-1:0] i_sw,
  input  logic         i_hold,
  output logic [W-1:0] o_data_switch,
  output logic         o_start,
  output logic         o_btn_level
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 2);

  logic [0:0]   btn_sync;
  logic [W-1:0] sw_sync;

  sync_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .d     (i_btn_start),
    .q     (btn_sync)
  );

  sync_chain #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sw_sync (
    .clk   (i_clk),
    .rst_n (i_rst),
    .d     (i_sw),
    .q     (sw_sync)
  );

  btn_state_t    state, state_next;
  logic [CW-1:0] bcnt, bcnt_next;
  logic          start_next;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      bcnt    <= '0;
      o_start <= 1'b0;
    end else begin
      state   <= state_next;
      bcnt    <= bcnt_next;
      o_start <= start_next;
    end
  end

  // The wait states leave on the sample that completes DEB_CYCLES agreeing samples.
  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    case (state)
      IDLE: begin
        if (btn_sync[0]) begin
          state_next = PRESS_WAIT;
          bcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync[0]) begin
          state_next = IDLE;
          bcnt_next  = '0;
        end else begin
          bcnt_next = bcnt + CW'(1);
          if (bcnt == CNT_LAST) begin
            state_next = PRESSED;
          end
        end
      end
      PRESSED: begin
        if (!btn_sync[0]) begin
          state_next = RELEASE_WAIT;
          bcnt_next  = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync[0]) begin
          state_next = PRESSED;
          bcnt_next  = '0;
        end else begin
          bcnt_next = bcnt + CW'(1);
          if (bcnt == CNT_LAST) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        bcnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    start_next  = (state == PRESS_WAIT) && btn_sync[0] && (bcnt == CNT_LAST);
    o_btn_level = (state == PRESSED) || (state == RELEASE_WAIT);
  end

  logic [W-1:0]  sw_cand;
  logic [CW-1:0] scnt;

  // Any bit change restarts the whole-word count; a settled word waits out i_hold.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sw_cand       <= '0;
      scnt          <= '0;
      o_data_switch <= '0;
    end else begin
      if (sw_sync != sw_cand) begin
        sw_cand <= sw_sync;
        scnt    <= '0;
      end else if (scnt != CNT_MAX) begin
        scnt <= scnt + CW'(1);
      end
      if ((scnt == CNT_MAX) && !i_hold) begin
        o_data_switch <= sw_cand;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a sliding-window reference model predicts
// every cycle's outputs and a monitor compares them after each clock edge.
module tb_input_conditioner;

  localparam int W       = 8;
  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int LATENCY = SYNC + DEB - 1;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         btn   = 1'b0;
  logic         hold  = 1'b0;
  logic [W-1:0] sw    = '0;
  logic [W-1:0] o_data_switch;
  logic         o_start;
  logic         o_btn_level;

  input_conditioner #(
    .W           (W),
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_btn_start   (btn),
    .i_sw          (sw),
    .i_hold        (hold),
    .o_data_switch (o_data_switch),
    .o_start       (o_start),
    .o_btn_level   (o_btn_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         start;
    logic         level;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_count = 0;
  int   last_start_edge = -1;
  int   start_count = 0;

  logic         btn_dly[$];
  logic [W-1:0] sw_dly[$];
  logic         btn_win[$];
  logic [W-1:0] sw_win[$];
  logic         m_level;
  logic [W-1:0] m_data;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    btn_dly.delete(); sw_dly.delete(); btn_win.delete(); sw_win.delete();
    for (int i = 0; i < SYNC; i++) begin
      btn_dly.push_back(1'b0);
      sw_dly.push_back('0);
    end
    for (int i = 0; i < DEB; i++) begin
      btn_win.push_back(1'b0);
      sw_win.push_back('0);
    end
    m_level = 1'b0;
    m_data  = '0;
  endfunction

  // Level flips once the last DEB synced samples all disagree with it; the word
  // follows once the DEB samples before this edge agree and hold is low.
  function automatic exp_t model_step(input logic b, input logic [W-1:0] s, input logic h, input logic r);
    exp_t         e;
    logic         b_s;
    logic [W-1:0] s_s;
    int           ones;
    bit           all_eq;
    e = '0;
    if (!r) begin
      model_reset();
      return e;
    end
    b_s = btn_dly.pop_front(); btn_dly.push_back(b);
    s_s = sw_dly.pop_front();  sw_dly.push_back(s);
    all_eq = 1'b1;
    foreach (sw_win[i]) if (sw_win[i] != sw_win[0]) all_eq = 1'b0;
    if (all_eq && !h) m_data = sw_win[0];
    void'(sw_win.pop_front()); sw_win.push_back(s_s);
    void'(btn_win.pop_front()); btn_win.push_back(b_s);
    ones = 0;
    foreach (btn_win[i]) ones += int'(btn_win[i]);
    if (!m_level && ones == DEB) begin
      m_level = 1'b1;
      e.start = 1'b1;
    end else if (m_level && ones == 0) begin
      m_level = 1'b0;
    end
    e.data  = m_data;
    e.level = m_level;
    return e;
  endfunction

  task automatic apply_stimulus(input logic b, input logic [W-1:0] s, input logic h, input logic r);
    @(negedge clk);
    btn = b; sw = s; hold = h; rst_n = r;
    if (!r) begin
      #1;
      check_output("async_rst_data", o_data_switch, 0);
      check_output("async_rst_start", o_start, 0);
      check_output("async_rst_level", o_btn_level, 0);
    end
    exp_q.push_back(model_step(b, s, h, r));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    edge_count++;
    if (o_start) begin
      start_count++;
      last_start_edge = edge_count;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("sb_data", o_data_switch, e.data);
      check_output("sb_start", o_start, e.start);
      check_output("sb_level", o_btn_level, e.level);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    int press_edge;
    logic bounce_press[6];
    logic bounce_rel[3];
    logic         rb, rh, rr;
    logic [W-1:0] rs;
    int           bit_idx;

    bounce_press = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bounce_rel   = '{1'b0, 1'b1, 1'b0};
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (5) apply_stimulus(1'b0, '0, 1'b0, 1'b1);

    // Clean press
    s0 = start_count;
    apply_stimulus(1'b1, sw, 1'b0, 1'b1);
    press_edge = edge_count + 1;
    repeat (19) apply_stimulus(1'b1, sw, 1'b0, 1'b1);
    check_output("clean_pulses", start_count - s0, 1);
    check_output("clean_latency", last_start_edge - press_edge, LATENCY);
    check_output("clean_level", o_btn_level, 1);
    repeat (10) apply_stimulus(1'b0, sw, 1'b0, 1'b1);

    // Bouncy press and release
    s0 = start_count;
    foreach (bounce_press[i]) apply_stimulus(bounce_press[i], sw, 1'b0, 1'b1);
    repeat (10) apply_stimulus(1'b1, sw, 1'b0, 1'b1);
    foreach (bounce_rel[i]) apply_stimulus(bounce_rel[i], sw, 1'b0, 1'b1);
    repeat (10) apply_stimulus(1'b0, sw, 1'b0, 1'b1);
    check_output("bouncy_pulses", start_count - s0, 1);
    check_output("bouncy_release_level", o_btn_level, 0);

    // Switch change and short glitch
    repeat (8) apply_stimulus(1'b0, 8'hA5, 1'b0, 1'b1);
    check_output("switch_settled", o_data_switch, 8'hA5);
    repeat (2) apply_stimulus(1'b0, 8'hA4, 1'b0, 1'b1);
    repeat (8) apply_stimulus(1'b0, 8'hA5, 1'b0, 1'b1);
    check_output("switch_glitch", o_data_switch, 8'hA5);

    // Hold freezes the word until released
    repeat (10) apply_stimulus(1'b0, 8'h3C, 1'b1, 1'b1);
    check_output("hold_frozen", o_data_switch, 8'hA5);
    apply_stimulus(1'b0, 8'h3C, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_output("hold_release", o_data_switch, 8'h3C);
    repeat (3) apply_stimulus(1'b0, 8'h3C, 1'b0, 1'b1);

    // Reset while the press counter is mid-way
    s0 = start_count;
    repeat (5) apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    repeat (2) apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    check_output("rst_press_no_pulse", start_count - s0, 0);
    apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    press_edge = edge_count + 1;
    repeat (15) apply_stimulus(1'b1, 8'h3C, 1'b0, 1'b1);
    check_output("rst_press_pulses", start_count - s0, 1);
    check_output("rst_press_latency", last_start_edge - press_edge, LATENCY);
    repeat (10) apply_stimulus(1'b0, 8'h3C, 1'b0, 1'b1);

    // Repeated presses
    s0 = start_count;
    for (int k = 0; k < 3; k++) begin
      repeat (8) apply_stimulus(1'b1, sw, 1'b0, 1'b1);
      repeat (8) apply_stimulus(1'b0, sw, 1'b0, 1'b1);
    end
    check_output("repeat_pulses", start_count - s0, 3);

    // Randomized bouncing, switch churn, hold and occasional reset
    rb = btn; rs = sw; rh = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5) == 0) rb = ~rb;
      if ($urandom_range(11) == 0) begin
        rs = W'($urandom_range(255));
      end else if ($urandom_range(15) == 0) begin
        bit_idx = $urandom_range(W - 1);
        rs[bit_idx] = ~rs[bit_idx];
      end
      if ($urandom_range(7) == 0) rh = ~rh;
      rr = ($urandom_range(149) != 0);
      apply_stimulus(rb, rs, rh, rr);
    end

    repeat (2) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that feeds the bit-serial core's switch-data and start inputs.
- Synchronises the raw board switches and start button to i_clk, debounces both, and drives a stable switch word on o_data_switch.
- Produces exactly one single-cycle o_start pulse per debounced button press.
- Freezes the switch word while the core is mid-instruction (i_hold).

Parameters:
- W, 8, switch bus width
- SYNC_STAGES, 2, flip-flop stages in each synchroniser (minimum 2)
- DEB_CYCLES, 16, consecutive stable synced samples required to accept a new level (minimum 2)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_btn_start  in  1  raw start push-button, asynchronous, bouncy
- i_sw  in  W  raw slide switches, asynchronous, bouncy
- i_hold  in  1  high = core busy; o_data_switch must not change
- o_data_switch  out  W  debounced, held switch word to the core
- o_start  out  1  one-cycle start pulse to the core
- o_btn_level  out  1  debounced button level, for status LED

Behaviour:
- Reset (i_rst=0, asynchronous):
  - all synchroniser flops = 0; counters = 0; button FSM = IDLE
  - o_data_switch = 0, o_start = 0, o_btn_level = 0
  - switch candidate register = 0
- Release of i_rst is synchronous to i_clk. Reset asserted mid-debounce or mid-pulse aborts immediately; no pulse is emitted after release unless a full new press completes.
- Synchronisers: SYNC_STAGES-deep flop chain per bit. All logic below uses synced values only.
- Button FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: synced=1 -> PRESS_WAIT, cnt=0; otherwise stay.
  - PRESS_WAIT: synced=1 -> cnt++. When cnt reaches DEB_CYCLES-1 -> PRESSED, o_start=1 for exactly that one transition cycle. synced=0 -> IDLE, cnt=0.
  - PRESSED: synced=0 -> RELEASE_WAIT, cnt=0; otherwise stay. No further pulses while held.
  - RELEASE_WAIT: synced=0 -> cnt++. When cnt reaches DEB_CYCLES-1 -> IDLE. synced=1 -> PRESSED, cnt=0; a bounce does not re-trigger.
  - o_btn_level = 1 in PRESSED and RELEASE_WAIT; otherwise 0.
- Start latency: raw rising edge sampled at edge N and held steady gives o_start high in the cycle following edge N+SYNC_STAGES+DEB_CYCLES-1. With defaults this is 17 edges after the press.
- o_start is registered, never combinational, and never high two consecutive cycles.
- Switch debounce:
  - synced word != candidate -> candidate <= synced word, scnt <= 0.
  - Otherwise scnt increments, saturating at DEB_CYCLES-1.
  - scnt == DEB_CYCLES-1 and i_hold=0 -> o_data_switch <= candidate; a no-op if already equal.
  - i_hold=1: o_data_switch frozen. A candidate that became stable during hold is applied on the first cycle with i_hold=0, provided it is still stable.
  - Any single-bit change restarts the whole-word count.
- Simultaneous events: if o_start fires in the same cycle that o_data_switch updates, the core sees the updated word one cycle after the pulse. The core samples data on o_start+1 or later; a press shorter than the switch settle time is a user-rule violation, not handled.
- Counter width: $clog2(DEB_CYCLES). No wrap-around is permitted; counters saturate.

Decomposition:
- Package bs_input_pkg holds:
  - button state enum btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}
  - default constants for SYNC_STAGES and DEB_CYCLES
- Sub-module sync_chain (parameter width, stages) is instantiated twice: once for the button, once for the switch bus.
- The debounce logic stays in input_conditioner.

Test Plan (DEB_CYCLES=4, SYNC_STAGES=2):
- Clean press: i_btn_start 0->1, held 20 cycles -> one o_start pulse 5 edges after sampling edge; o_btn_level=1; no second pulse.
- Bouncy press: pattern 1,0,1,1,0,1 then steady 1 -> single o_start, only after 4 consecutive synced 1s; bouncy release 0,1,0 then steady 0 -> no pulse, FSM returns to IDLE.
- Switch change: i_sw 0x00 -> 0xA5 steady, i_hold=0 -> o_data_switch=0xA5 exactly 2+4 edges later. Glitch 0xA5->0xA4->0xA5 lasting 2 cycles -> output stays 0xA5.
- Hold: i_hold=1, i_sw -> 0x3C for 10 cycles -> o_data_switch unchanged; i_hold 1->0 -> 0x3C on the next edge.
- Reset mid-press: i_rst=0 during PRESS_WAIT (cnt=2) -> all outputs 0 asynchronously. After release with the button still held, a full 2+4 cycle count is required before o_start.
- Repeated presses: three debounced press/release cycles -> exactly three o_start pulses, each one cycle wide.
